stream_demux1to2: RTL and testbench

STREAM_DEMUX1TO2 -- requirements
Module: stream_demux1to2

---
 rtl/stream_demux1to2.sv | 97 +++++++++
 tb/tb_stream_demux1to2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1to2.sv
// One-to-two stream demultiplexer: each accepted word is steered by in_sel into
// one of two independent single-entry output slots, with per-port handshake counters.
module stream_demux1to2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic hs0, hs1, accept, load0, load1;

  assign hs0 = valid0_q && out0_ready;
  assign hs1 = valid1_q && out1_ready;

  // A slot draining this cycle can take a new word without a bubble.
  assign in_ready = in_sel ? (!valid1_q || hs1) : (!valid0_q || hs0);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !in_sel;
  assign load1    = accept && in_sel;

  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    if (hs0)   valid0_d = 1'b0;
    if (hs1)   valid1_d = 1'b0;
    if (load0) begin
      valid0_d = 1'b1;
      data0_d  = in_data;
    end
    if (load1) begin
      valid1_d = 1'b1;
      data1_d  = in_data;
    end
  end

  // Clear wins over a same-cycle handshake increment.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (hs0) cnt0_d = cnt0_q + 1'b1;
      if (hs1) cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign out0_valid = valid0_q;
  assign out1_valid = valid1_q;
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux1to2.sv
// Directed self-checking bench for stream_demux1to2, built with a 4-bit counter
// so the wrap boundary is reachable in a few cycles.
module tb_stream_demux1to2;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_sel, clr_cnt;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out1_valid, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int checkCount = 0;
  int errorCount = 0;

  stream_demux1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .clr_cnt(clr_cnt), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                               input logic r0, input logic r1, input logic clr);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    clr_cnt    = clr;
  endtask

  // Advance one edge and settle just after it, so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_out0_valid", out0_valid, 0);
    checkOutput("rst_out1_valid", out1_valid, 0);
    checkOutput("rst_out0_data", out0_data, 0);
    checkOutput("rst_out1_data", out1_data, 0);
    checkOutput("rst_cnt0", cnt0, 0);
    checkOutput("rst_cnt1", cnt1, 0);
    rst_n = 1'b1;
    step();
    checkOutput("rst_ready_sel0", in_ready, 1);
    in_sel = 1'b1;
    #1;
    checkOutput("rst_ready_sel1", in_ready, 1);

    // Basic steer to out1
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("steer_out1_valid", out1_valid, 1);
    checkOutput("steer_out1_data", out1_data, 32'hDEADBEEF);
    checkOutput("steer_out0_valid", out0_valid, 0);
    checkOutput("steer_ready_sel1", in_ready, 0);
    in_sel = 1'b0;
    #1;
    checkOutput("steer_ready_sel0", in_ready, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("drain1_valid", out1_valid, 0);
    checkOutput("drain1_data_held", out1_data, 32'hDEADBEEF);
    checkOutput("drain1_cnt1", cnt1, 1);

    // Backpressure on slot 0
    applyStimulus(1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      step();
      checkOutput("bp_out0_data", out0_data, 32'h11);
      checkOutput("bp_out0_valid", out0_valid, 1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bp_cnt0", cnt0, 1);
    checkOutput("bp_out0_empty", out0_valid, 0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("clr_cnt0", cnt0, 0);
    checkOutput("clr_cnt1", cnt1, 0);

    // Back-to-back streaming into out0
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("stream_in_ready", in_ready, 1);
      step();
      checkOutput("stream_out0_valid", out0_valid, 1);
      checkOutput("stream_out0_data", out0_data, i);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("stream_cnt0", cnt0, 8);
    checkOutput("stream_out0_empty", out0_valid, 0);

    // Parallel drain
    applyStimulus(1'b1, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("par_out0_data", out0_data, 32'hA);
    checkOutput("par_out1_data", out1_data, 32'hB);
    checkOutput("par_both_valid", {out0_valid, out1_valid}, 2'b11);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("par_cnt0", cnt0, 9);
    checkOutput("par_cnt1", cnt1, 1);
    checkOutput("par_both_empty", {out0_valid, out1_valid}, 2'b00);

    // Counter wrap on out1
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b1, 1'b0);
      step();
    end
    checkOutput("wrap_cnt1_15", cnt1, 15);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("wrap_cnt1_0", cnt1, 0);
    checkOutput("wrap_last_data", out1_data, 32'h10F);

    // Clear beats a same-cycle increment
    applyStimulus(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("pre_clr_cnt0", cnt0, 1);
    applyStimulus(1'b1, 1'b0, 32'h66, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("clr_hs_cnt0", cnt0, 0);
    checkOutput("clr_hs_cnt1", cnt1, 0);
    checkOutput("clr_hs_out0_empty", out0_valid, 0);

    // Reset in the middle of operation
    applyStimulus(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_both_full", {out0_valid, out1_valid}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {out0_valid, out1_valid}, 2'b00);
    checkOutput("mid_rst_out0_data", out0_data, 0);
    checkOutput("mid_rst_out1_data", out1_data, 0);
    #1;
    rst_n = 1'b1;
    step();
    checkOutput("mid_ready", in_ready, 1);
    checkOutput("mid_cnt0", cnt0, 0);
    checkOutput("mid_cnt1", cnt1, 0);
    checkOutput("mid_still_empty", {out0_valid, out1_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
